// File: rtl/concat_requant_pkg.sv
// Shared constants and lane-index helper for the concat requantiser.
// PICTURE_NUM and SCALE_LATENCY default here when no shared build header
// has already defined them, so the multiplier wrapper and this block agree.
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
`ifndef SCALE_LATENCY
`define SCALE_LATENCY 4
`endif

package concat_requant_pkg;
  localparam int PICTURE_NUM       = `PICTURE_NUM;
  localparam int SCALE_LATENCY_DEF = `SCALE_LATENCY;
  localparam int SCALE_W           = 32;
  localparam int QUANT_W           = 8;

  // Lane k for channel j of picture i: k = j*PICTURE_NUM + i.
  function automatic int lane_idx(input int j, input int i);
    return j * PICTURE_NUM + i;
  endfunction
endpackage

// File: rtl/concat_requant_lane.sv
// One requant lane: (optionally rounded) right shift, add zero point,
// saturate to uint8, one register stage.
// Build option: CONCAT_REQUANT_ROUND_EN selects round-half-up before the
// shift; otherwise the shift truncates. Latency is identical in both builds.
module concat_requant_lane
  import concat_requant_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [SCALE_W-1:0] scale_data,
  input  logic [4:0]         shift,
  input  logic [7:0]         zero_point,
  output logic [QUANT_W-1:0] quant_data
);

  logic [SCALE_W:0]   biased;
  logic [SCALE_W:0]   shifted;
  logic [SCALE_W:0]   sum;
  logic [QUANT_W-1:0] sat;

  // Combinational shift / offset / clamp. Every result is assigned on all
  // paths; 33 bits hold both the rounding carry and the zero-point add.
  always_comb begin
`ifdef CONCAT_REQUANT_ROUND_EN
    biased = {1'b0, scale_data}
           + ((shift != 5'd0) ? (33'd1 << (shift - 5'd1)) : 33'd0);
`else
    biased = {1'b0, scale_data};
`endif
    shifted = biased >> shift;
    sum     = shifted + {25'd0, zero_point};
    sat     = (sum > 33'd255) ? 8'hFF : sum[7:0];
  end

  // Output register; the valid bit travels alongside it in the top.
  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) quant_data <= '0;
    else     quant_data <= sat;
  end

endmodule

// File: rtl/concat_requant.sv
// Concat requantiser: aligns valid with the scaling multiplier output,
// requantises every lane to uint8 and buffers packed beats in a FWFT FIFO
// behind a valid/ready interface. Ready_Out throttles upstream so that a
// compliant producer never hits a full FIFO.
// Build option: CONCAT_REQUANT_ROUND_EN (see concat_requant_lane).
module concat_requant
  import concat_requant_pkg::*;
#(
  parameter int RE_CHANNEL_IN_NUM = 16,
  parameter int SCALE_LATENCY     = SCALE_LATENCY_DEF,
  parameter int FIFO_DEPTH        = 8,
  parameter int PIX_CNT_W         = 20
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          Start_In,
  input  logic [PIX_CNT_W-1:0]                          Pixel_Num_In,
  input  logic                                          Data_Valid_In,
  output logic                                          Ready_Out,
  input  logic [PICTURE_NUM*RE_CHANNEL_IN_NUM*SCALE_W-1:0] Scale_Data_In,
  input  logic [4:0]                                    Shift_In,
  input  logic [7:0]                                    Zero_Point_In,
  output logic [PICTURE_NUM*RE_CHANNEL_IN_NUM*QUANT_W-1:0] Quant_Data_Out,
  output logic                                          Quant_Valid_Out,
  input  logic                                          Quant_Ready_In,
  output logic                                          Done_Out,
  output logic                                          Overflow_Out
);

  localparam int LANES = PICTURE_NUM * RE_CHANNEL_IN_NUM;
  localparam int OUT_W = LANES * QUANT_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = $clog2(FIFO_DEPTH + SCALE_LATENCY + 2) + 1;

  logic [SCALE_LATENCY-1:0] valid_dly;
  logic                     req_valid;
  logic [OUT_W-1:0]         lane_q;
  logic [OUT_W-1:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_wr;
  logic                     fifo_rd;
  logic [SUM_W-1:0]         occupancy;
  logic [PIX_CNT_W-1:0]     beat_cnt;
  logic [PIX_CNT_W-1:0]     pix_num;

  for (genvar j = 0; j < RE_CHANNEL_IN_NUM; j++) begin : g_ch
    for (genvar i = 0; i < PICTURE_NUM; i++) begin : g_pic
      localparam int K = lane_idx(j, i);
      concat_requant_lane u_lane (
        .clk        (clk),
        .rst        (rst),
        .scale_data (Scale_Data_In[K*SCALE_W +: SCALE_W]),
        .shift      (Shift_In),
        .zero_point (Zero_Point_In),
        .quant_data (lane_q[K*QUANT_W +: QUANT_W])
      );
    end
  end

  // Valid-only delay line matching the multiplier latency, then the requant stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_dly <= '0;
      req_valid <= 1'b0;
    end else begin
      valid_dly <= {valid_dly[SCALE_LATENCY-2:0], Data_Valid_In};
      req_valid <= valid_dly[SCALE_LATENCY-1];
    end
  end

  // A write at full is only taken when a read frees a slot in the same cycle.
  assign fifo_rd = (fifo_count != '0) && Quant_Ready_In;
  assign fifo_wr = req_valid && ((fifo_count != CNT_W'(FIFO_DEPTH)) || fifo_rd);

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
    end
  end

  // FIFO storage write port.
  // NOTE: the data array is not reset; emptiness is tracked by fifo_count alone.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= lane_q;
  end

  assign Quant_Valid_Out = (fifo_count != '0);
  assign Quant_Data_Out  = Quant_Valid_Out ? fifo_mem[rd_ptr] : '0;

  // Every beat already committed to the FIFO: buffered, in the delay line,
  // in the requant stage, plus the one entering this cycle.
  // NOTE: the default is assigned first so no path leaves occupancy unassigned.
  always_comb begin
    occupancy = SUM_W'(fifo_count) + SUM_W'(req_valid) + SUM_W'(Data_Valid_In);
    for (int i = 0; i < SCALE_LATENCY; i++) begin
      occupancy = occupancy + SUM_W'(valid_dly[i]);
    end
  end

  // Registered ready: high while one more beat still fits behind everything committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) Ready_Out <= 1'b0;
    else     Ready_Out <= (occupancy < SUM_W'(FIFO_DEPTH));
  end

  // Layer control: beat counter, done pulse, sticky overflow. Start wins over a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt     <= '0;
      pix_num      <= '0;
      Done_Out     <= 1'b0;
      Overflow_Out <= 1'b0;
    end else begin
      Done_Out <= 1'b0;
      if (Start_In) begin
        beat_cnt     <= '0;
        pix_num      <= Pixel_Num_In;
        Overflow_Out <= 1'b0;
      end else begin
        if (Data_Valid_In && !Ready_Out) Overflow_Out <= 1'b1;
        if (fifo_rd && (pix_num != '0) && (beat_cnt != pix_num)) begin
          beat_cnt <= beat_cnt + PIX_CNT_W'(1);
          if (beat_cnt + PIX_CNT_W'(1) == pix_num) Done_Out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_concat_requant.sv
// Self-checking bench for concat_requant: directed steps plus a randomized
// phase, all checked against a behavioural scoreboard of requantised beats.
module tb_concat_requant;
  import concat_requant_pkg::*;

  localparam int CH    = 16;
  localparam int LANES = PICTURE_NUM * CH;
  localparam int IN_W  = LANES * 32;
  localparam int OUT_W = LANES * 8;
  localparam int LAT   = SCALE_LATENCY_DEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              Start_In;
  logic [19:0]       Pixel_Num_In;
  logic              Data_Valid_In;
  logic              Ready_Out;
  logic [IN_W-1:0]   Scale_Data_In;
  logic [4:0]        Shift_In;
  logic [7:0]        Zero_Point_In;
  logic [OUT_W-1:0]  Quant_Data_Out;
  logic              Quant_Valid_Out;
  logic              Quant_Ready_In;
  logic              Done_Out;
  logic              Overflow_Out;

  concat_requant dut (
    .clk             (clk),
    .rst             (rst),
    .Start_In        (Start_In),
    .Pixel_Num_In    (Pixel_Num_In),
    .Data_Valid_In   (Data_Valid_In),
    .Ready_Out       (Ready_Out),
    .Scale_Data_In   (Scale_Data_In),
    .Shift_In        (Shift_In),
    .Zero_Point_In   (Zero_Point_In),
    .Quant_Data_Out  (Quant_Data_Out),
    .Quant_Valid_Out (Quant_Valid_Out),
    .Quant_Ready_In  (Quant_Ready_In),
    .Done_Out        (Done_Out),
    .Overflow_Out    (Overflow_Out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int done_pulses = 0;

  // Scoreboard and upstream multiplier model
  logic [OUT_W-1:0] exp_q [$];
  logic [IN_W-1:0]  slot_data [8];
  bit               slot_vld  [8];
  int               m_cnt  = 0;
  int               m_pix  = 0;
  bit               m_done = 1'b0;
  bit               m_ovf  = 1'b0;

  task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference requantisation straight from the arithmetic rules.
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] d, input int sh, input int zp);
    logic [OUT_W-1:0] r;
    longint unsigned x;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      x = longint'(d[k*32 +: 32]);
`ifdef CONCAT_REQUANT_ROUND_EN
      if (sh != 0) x = x + (longint'(1) << (sh - 1));
`endif
      x = (x >> sh) + longint'(zp);
      r[k*8 +: 8] = (x > 255) ? 8'hFF : 8'(x);
    end
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rand_vec();
    logic [IN_W-1:0] r;
    for (int k = 0; k < LANES; k++) begin
      case ($urandom_range(0, 3))
        0:       r[k*32 +: 32] = 32'($urandom_range(0, 511));
        1:       r[k*32 +: 32] = 32'hFFFF_FFFF - 32'($urandom_range(0, 255));
        default: r[k*32 +: 32] = $urandom;
      endcase
    end
    return r;
  endfunction

  // Offer a beat this cycle; its scaled data appears LAT cycles later.
  task automatic issue(input logic [IN_W-1:0] d, input bit keep);
    Data_Valid_In = 1'b1;
    slot_data[(cycle + LAT) % 8] = d;
    slot_vld[(cycle + LAT) % 8]  = 1'b1;
    if (keep) exp_q.push_back(model(d, int'(Shift_In), int'(Zero_Point_In)));
  endtask

  // Observe the current cycle, advance one clock, check control outputs.
  task automatic tick();
    bit xfer;
    logic [OUT_W-1:0] exp_v;
    xfer = Quant_Valid_Out && Quant_Ready_In;
    if (Quant_Valid_Out && exp_q.size() == 0) begin
      check("spurious_beat", OUT_W'(Quant_Valid_Out), '0);
    end else if (xfer) begin
      exp_v = exp_q.pop_front();
      check("beat_data", Quant_Data_Out, exp_v);
    end
    if (Start_In) begin
      m_cnt = 0; m_pix = int'(Pixel_Num_In); m_done = 1'b0; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (Data_Valid_In && !Ready_Out) m_ovf = 1'b1;
      if (xfer && m_pix != 0 && m_cnt < m_pix) begin
        m_cnt++;
        m_done = (m_cnt == m_pix);
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    check("done_out", OUT_W'(Done_Out), OUT_W'(m_done));
    check("overflow_out", OUT_W'(Overflow_Out), OUT_W'(m_ovf));
    if (Done_Out) done_pulses++;
    Data_Valid_In = 1'b0;
    Start_In      = 1'b0;
    if (slot_vld[cycle % 8]) begin
      Scale_Data_In = slot_data[cycle % 8];
      slot_vld[cycle % 8] = 1'b0;
    end else begin
      Scale_Data_In = rand_vec();
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_complete", OUT_W'(exp_q.size()), '0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!Quant_Valid_Out && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic directed_beat(input string tag, input logic [IN_W-1:0] d, input int lane, input logic [7:0] exp_b);
    issue(d, 1'b1);
    tick();
    wait_valid(20);
    check({tag, "_valid"}, OUT_W'(Quant_Valid_Out), OUT_W'(1));
    check(tag, OUT_W'(Quant_Data_Out[lane*8 +: 8]), OUT_W'(exp_b));
    drain(20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the sequence finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] d;
    int c0, first, highs, accepted, sent, n;

    rst = 1'b1; Start_In = 1'b0; Pixel_Num_In = '0; Data_Valid_In = 1'b0;
    Scale_Data_In = '0; Shift_In = '0; Zero_Point_In = '0; Quant_Ready_In = 1'b0;
    for (int i = 0; i < 8; i++) slot_vld[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", OUT_W'(Quant_Valid_Out), '0);
    check("rst_data", Quant_Data_Out, '0);
    check("rst_ready", OUT_W'(Ready_Out), '0);
    check("rst_done", OUT_W'(Done_Out), '0);
    check("rst_overflow", OUT_W'(Overflow_Out), '0);
    rst = 1'b0;
    tick();
    check("ready_after_first_clk", OUT_W'(Ready_Out), OUT_W'(1));

    // Directed requant values
    Quant_Ready_In = 1'b1;
    Shift_In = 5'd8; Zero_Point_In = 8'd3;
    d = rand_vec(); d[31:0] = 32'h0000_1234;
    directed_beat("shift8_zp3", d, 0, 8'h15);
    Shift_In = 5'd0;
    d = rand_vec(); d[5*32 +: 32] = 32'hFFFF_FFFF;
    directed_beat("saturate", d, 5, 8'hFF);
    Shift_In = 5'd8; Zero_Point_In = 8'd0;
    d = rand_vec(); d[31:0] = 32'h0000_0180;
`ifdef CONCAT_REQUANT_ROUND_EN
    directed_beat("round_half", d, 0, 8'd2);
`else
    directed_beat("round_half", d, 0, 8'd1);
`endif

    // Single-beat latency
    repeat (3) tick();
    c0 = cycle; first = -1; highs = 0;
    issue(rand_vec(), 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (Quant_Valid_Out) begin
        highs++;
        if (first < 0) first = cycle;
      end
    end
    check("latency", OUT_W'(first - c0), OUT_W'(LAT + 2));
    check("single_valid_cycle", OUT_W'(highs), OUT_W'(1));

    // Backpressure: stream while ready, downstream stalled
    Quant_Ready_In = 1'b0;
    Shift_In = 5'd4; Zero_Point_In = 8'd17;
    accepted = 0;
    for (int k = 0; k < 30; k++) begin
      if (Ready_Out) begin
        issue(rand_vec(), 1'b1);
        accepted++;
      end
      tick();
    end
    check("accepted_before_stall", OUT_W'(accepted), OUT_W'(8));
    check("ready_low_when_full", OUT_W'(Ready_Out), '0);
    check("no_overflow_when_obeyed", OUT_W'(Overflow_Out), '0);

    // Forced beat against a full FIFO: flagged and dropped
    issue(rand_vec(), 1'b0);
    tick();
    check("overflow_set", OUT_W'(Overflow_Out), OUT_W'(1));
    repeat (10) tick();
    Quant_Ready_In = 1'b1;
    drain(40);
    repeat (10) tick();
    check("overflow_sticky", OUT_W'(Overflow_Out), OUT_W'(1));

    // Five-beat layer with random stalls
    Pixel_Num_In = 20'd5; Start_In = 1'b1;
    tick();
    check("start_clears_overflow", OUT_W'(Overflow_Out), '0);
    done_pulses = 0; sent = 0; n = 0;
    while ((sent < 5 || exp_q.size() != 0) && n < 300) begin
      Quant_Ready_In = 1'($urandom_range(0, 1));
      if (sent < 5 && Ready_Out && $urandom_range(0, 1) == 1) begin
        issue(rand_vec(), 1'b1);
        sent++;
      end
      tick();
      n++;
    end
    check("layer5_drained", OUT_W'(exp_q.size()), '0);
    Quant_Ready_In = 1'b1;
    repeat (5) tick();
    check("done_one_pulse", OUT_W'(done_pulses), OUT_W'(1));

    // Reset with three beats buffered
    Quant_Ready_In = 1'b0;
    for (int k = 0; k < 3; k++) begin
      issue(rand_vec(), 1'b1);
      tick();
    end
    repeat (8) tick();
    check("buffered_before_rst", OUT_W'(Quant_Valid_Out), OUT_W'(1));
    rst = 1'b1;
    #1;
    check("rst_mid_valid", OUT_W'(Quant_Valid_Out), '0);
    check("rst_mid_data", Quant_Data_Out, '0);
    check("rst_mid_ready", OUT_W'(Ready_Out), '0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) slot_vld[i] = 1'b0;
    m_cnt = 0; m_pix = 0; m_done = 1'b0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    Quant_Ready_In = 1'b1;
    tick();
    check("ready_after_rst", OUT_W'(Ready_Out), OUT_W'(1));
    repeat (10) tick();
    check("empty_after_rst", OUT_W'(Quant_Valid_Out), '0);

    // Randomized layers, including a restart mid-layer and a zero-length layer
    done_pulses = 0;
    for (int layer = 0; layer < 3; layer++) begin
      Shift_In = 5'($urandom_range(0, 31));
      Zero_Point_In = 8'($urandom_range(0, 255));
      Pixel_Num_In = (layer == 0) ? 20'd0 : 20'($urandom_range(3, 20));
      Start_In = 1'b1;
      tick();
      for (int k = 0; k < 150; k++) begin
        Quant_Ready_In = ($urandom_range(0, 3) != 0);
        if (k == 75) Start_In = 1'b1;
        if (Ready_Out && $urandom_range(0, 2) != 0) issue(rand_vec(), 1'b1);
        tick();
      end
      Quant_Ready_In = 1'b1;
      repeat (LAT + 2) tick();
      drain(60);
      repeat (4) tick();
    end
    check("zero_layer_no_overflow", OUT_W'(Overflow_Out), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
